// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch request stage: holds the fetch address,
// drives a valid/ready request to instruction memory, and handles branch, pause and halt.
//
// state  | meaning
// IDLE   | paused, no fetch requested, pc held
// RUN    | fetch requested (valid=1), pc advances on accept or loads on branch
// HALTED | frozen until reset, halted=1
module pc_fetch_unit #(
   parameter int                 WIDTH      = 8,
   parameter logic [WIDTH-1:0]   RESET_ADDR = '0,
   parameter int                 STEP       = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             halt,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   input  logic             ready,
   output logic [WIDTH-1:0] pc,
   output logic             valid,
   output logic             wrap,
   output logic             halted
);

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t state;

   // extra top bit carries out of the MSB and feeds only the wrap pulse
   logic [WIDTH:0] inc_sum;
   assign inc_sum = {1'b0, pc} + {1'b0, STEP_W};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         pc     <= RESET_ADDR;
         valid  <= 1'b0;
         wrap   <= 1'b0;
         halted <= 1'b0;
      end else begin
         wrap <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  state <= RUN;
                  valid <= 1'b1;
               end
            end
            RUN: begin
               if (halt) begin
                  state  <= HALTED;
                  valid  <= 1'b0;
                  halted <= 1'b1;
               end else if (!en) begin
                  state <= IDLE;
                  valid <= 1'b0;
               end else if (ld) begin
                  // a branch replaces the outstanding fetch even if it was accepted
                  pc <= d;
               end else if (ready) begin
                  pc   <= inc_sum[WIDTH-1:0];
                  wrap <= inc_sum[WIDTH];
               end
            end
            HALTED: begin
               valid  <= 1'b0;
               halted <= 1'b1;
            end
            default: begin
               state  <= IDLE;
               valid  <= 1'b0;
               halted <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a mode/address reference model.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

   localparam int WIDTH = 8;
   localparam int STEP  = 1;
   localparam int RADDR = 0;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0, halt = 1'b0, ld = 1'b0, ready = 1'b0;
   logic [WIDTH-1:0] d = '0;
   logic [WIDTH-1:0] pc;
   logic             valid, wrap, halted;

   int n_vec = 0;
   int n_bad = 0;

   pc_fetch_unit #(.WIDTH(WIDTH), .RESET_ADDR(8'(RADDR)), .STEP(STEP)) dut (
      .clk(clk), .rst(rst), .en(en), .halt(halt), .ld(ld), .d(d),
      .ready(ready), .pc(pc), .valid(valid), .wrap(wrap), .halted(halted)
   );

   always #5 clk = ~clk;

   // reference model: mode 0 = paused, 1 = fetching, 2 = halted
   int m_mode = 0;
   int m_pc   = RADDR;
   bit m_wrap = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = 0;
         m_pc   = RADDR;
         m_wrap = 1'b0;
      end else begin
         int nxt;
         m_wrap = 1'b0;
         if (m_mode == 0) begin
            if (en) m_mode = 1;
         end else if (m_mode == 1) begin
            if (halt)      m_mode = 2;
            else if (!en)  m_mode = 0;
            else if (ld)   m_pc = int'(d);
            else if (ready) begin
               nxt    = m_pc + STEP;
               m_pc   = nxt % (1 << WIDTH);
               m_wrap = (nxt >= (1 << WIDTH));
            end
         end
      end
   end

   task automatic cmp(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // single compare process against the model, away from the active edge
   always @(negedge clk) begin
      cmp("model_pc",     int'(pc),     m_pc);
      cmp("model_valid",  int'(valid),  int'(m_mode == 1));
      cmp("model_halted", int'(halted), int'(m_mode == 2));
      cmp("model_wrap",   int'(wrap),   int'(m_wrap));
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic lit(input string name, input int got, input int exp);
      cmp(name, got, exp);
   endtask

   initial begin
      tick();
      rst = 1'b0;
      lit("rst_pc", int'(pc), 0);
      lit("rst_valid", int'(valid), 0);
      lit("rst_halted", int'(halted), 0);
      lit("rst_wrap", int'(wrap), 0);

      // sequential fetch, valid one edge after en
      en = 1'b1; ready = 1'b1;
      tick(); lit("t1_valid", int'(valid), 1); lit("t1_pc0", int'(pc), 8'h00);
      tick(); lit("t1_pc1", int'(pc), 8'h01);
      tick(); lit("t1_pc2", int'(pc), 8'h02);
      tick(); lit("t1_pc3", int'(pc), 8'h03);

      // stall with ready low
      ld = 1'b1; d = 8'h05; tick(); ld = 1'b0; ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); lit("t2_hold_pc", int'(pc), 8'h05); lit("t2_hold_valid", int'(valid), 1);
      end
      ready = 1'b1; tick(); lit("t2_pc6", int'(pc), 8'h06);

      // wrap
      ld = 1'b1; d = 8'hFF; ready = 1'b0; tick(); ld = 1'b0; ready = 1'b1;
      tick(); lit("t3_pc00", int'(pc), 8'h00); lit("t3_wrap1", int'(wrap), 1);
      ready = 1'b0;
      tick(); lit("t3_wrap0", int'(wrap), 0); lit("t3_pc_hold", int'(pc), 8'h00);

      // branch during stall, then accept
      ld = 1'b1; d = 8'h10; tick(); d = 8'h3C;
      tick(); lit("t4_pc3c", int'(pc), 8'h3C); lit("t4_valid", int'(valid), 1);
      ld = 1'b0; ready = 1'b1;
      tick(); lit("t4_pc3d", int'(pc), 8'h3D);

      // pause back to idle
      en = 1'b0; tick(); lit("pause_valid", int'(valid), 0); lit("pause_pc", int'(pc), 8'h3D);
      tick(); lit("pause_hold", int'(pc), 8'h3D);
      en = 1'b1; tick(); lit("resume_valid", int'(valid), 1); lit("resume_pc", int'(pc), 8'h3D);

      // halt beats branch, then everything ignored
      ld = 1'b1; d = 8'h20; ready = 1'b0; tick();
      halt = 1'b1; d = 8'h77;
      tick(); lit("t5_halted", int'(halted), 1); lit("t5_valid", int'(valid), 0); lit("t5_pc", int'(pc), 8'h20);
      halt = 1'b0; ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); lit("t5_frozen_pc", int'(pc), 8'h20); lit("t5_frozen_h", int'(halted), 1);
      end

      // async reset mid-cycle
      rst = 1'b1; #1;
      lit("rst_from_halt", int'(halted), 0);
      rst = 1'b0; ld = 1'b0; ready = 1'b0;
      tick(); tick();
      ld = 1'b1; d = 8'h42; tick(); ld = 1'b0;
      lit("t6_pc42", int'(pc), 8'h42);
      #1 rst = 1'b1;
      #1;
      lit("t6_pc", int'(pc), RADDR); lit("t6_valid", int'(valid), 0); lit("t6_halted", int'(halted), 0);
      #0.5 rst = 1'b0;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         tick();
         en    = ($urandom_range(0, 9) != 0);
         halt  = ($urandom_range(0, 59) == 0);
         ld    = ($urandom_range(0, 7) == 0);
         ready = $urandom_range(0, 1) == 1;
         d     = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         if ($urandom_range(0, 119) == 0) begin
            rst = 1'b1;
            #1 rst = 1'b0;
         end
      end

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
